// File: rtl/matrix_entry_module.sv
// ============================================================================
//  Module      : matrix_entry_module
//  Description : Captures the four 8-bit elements of a 2x2 matrix from the
//                slide switches, one element per debounced NEXT press, and
//                hands the completed matrix to the compute core with a
//                one-cycle done pulse and a valid level. CLEAR wipes entry.
//                Optional build macro INPUT_RANGE_CHECK_EN rejects element
//                values above MAX_VALUE with a one-cycle err_o pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_entry_module #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [7:0] MAX_VALUE       = 8'd99
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_clear,
    input  logic [7:0] sw_value,
    output logic [7:0] c11_o,
    output logic [7:0] c12_o,
    output logic [7:0] c21_o,
    output logic [7:0] c22_o,
    output logic [1:0] entry_idx_o,
    output logic       matrix_valid_o,
    output logic       load_done_o,
    output logic       err_o
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_ENTER = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    // Bit 0 = NEXT, bit 1 = CLEAR
    logic [1:0] btn_raw;
    logic [1:0] press_evt;
    logic       next_evt;
    logic       clr_evt;
    logic       accept;
    state_t     state_q;

    assign btn_raw  = {btn_clear, btn_next};
    assign next_evt = press_evt[0];
    assign clr_evt  = press_evt[1];

    // One synchronizer + debouncer + edge detector per button
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic             meta_q;
        logic             sync_q;
        logic             level_q;
        logic             level_prev_q;
        logic [CNT_W-1:0] cnt_q;

        // Level follows the synchronized input only after it has disagreed
        // for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample restarts.
        always_ff @(posedge clock_100Mhz or posedge reset) begin
            if (reset) begin
                meta_q       <= 1'b0;
                sync_q       <= 1'b0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
                cnt_q        <= '0;
            end else begin
                meta_q       <= btn_raw[gi];
                sync_q       <= meta_q;
                level_prev_q <= level_q;
                if (sync_q != level_q) begin
                    if (cnt_q == CNT_LAST) begin
                        level_q <= sync_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        // Single-cycle event on the rising edge of the debounced level
        assign press_evt[gi] = level_q & ~level_prev_q;
    end

`ifdef INPUT_RANGE_CHECK_EN
    assign accept = (sw_value <= MAX_VALUE);
`else
    // Every value is accepted; the OR keeps MAX_VALUE referenced and folds to 1
    assign accept = 1'b1 | (sw_value <= MAX_VALUE);
`endif

    // Entry FSM with registered element, index, valid and pulse outputs
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q        <= ST_ENTER;
            c11_o          <= 8'd0;
            c12_o          <= 8'd0;
            c21_o          <= 8'd0;
            c22_o          <= 8'd0;
            entry_idx_o    <= 2'd0;
            matrix_valid_o <= 1'b0;
            load_done_o    <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            load_done_o <= 1'b0;
            err_o       <= 1'b0;
            if (clr_evt) begin
                // Clear takes priority over a simultaneous NEXT event
                state_q        <= ST_ENTER;
                c11_o          <= 8'd0;
                c12_o          <= 8'd0;
                c21_o          <= 8'd0;
                c22_o          <= 8'd0;
                entry_idx_o    <= 2'd0;
                matrix_valid_o <= 1'b0;
            end else if (next_evt) begin
                case (state_q)
                    ST_ENTER: begin
                        if (!accept) begin
                            err_o <= 1'b1;
                        end else begin
                            case (entry_idx_o)
                                2'd0:    c11_o <= sw_value;
                                2'd1:    c12_o <= sw_value;
                                2'd2:    c21_o <= sw_value;
                                default: c22_o <= sw_value;
                            endcase
                            entry_idx_o <= entry_idx_o + 2'd1;
                            if (entry_idx_o == 2'd3) begin
                                state_q        <= ST_DONE;
                                matrix_valid_o <= 1'b1;
                                load_done_o    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // Restart press: value is not stored, old elements remain
                        state_q        <= ST_ENTER;
                        matrix_valid_o <= 1'b0;
                        entry_idx_o    <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
